// File: rtl/mux_nin1_rr.sv
// N-input selector with a one-deep registered output, explicit-select or round-robin arbitration.
// Optional macro MUX_PARITY_EN adds o_DaljaParitet, the XOR reduction of the loaded word.
module mux_nin1_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [N*WIDTH-1:0] i_Hyrja,
  input  logic [N-1:0]       i_Valid,
  output logic [N-1:0]       o_Ready,
  input  logic               i_Mode,
  input  logic [SELW-1:0]    i_S,
  output logic [WIDTH-1:0]   o_Dalja,
  output logic               o_DaljaValid,
  input  logic               i_DaljaReady,
  output logic [SELW-1:0]    o_Zgjedhja
`ifdef MUX_PARITY_EN
  ,
  output logic               o_DaljaParitet
`endif
);

  logic [WIDTH-1:0] r_dalja;
  logic             r_valid;
  logic [SELW-1:0]  r_sel;
  logic [SELW-1:0]  r_ptr;

  logic [WIDTH-1:0] w_ch [N];
  logic             w_free;
  logic             w_gnt_any;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_ch[gi]    = i_Hyrja[gi*WIDTH +: WIDTH];
      assign o_Ready[gi] = ~i_Reset & w_free & w_gnt_any & (w_gnt_idx == SELW'(gi));
    end
  endgenerate

  assign w_free = ~r_valid | i_DaljaReady;
  assign w_xfer = w_free & w_gnt_any;

  // Round-robin scan runs from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    int idx;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    idx        = 0;
    if (!i_Mode) begin
      for (int j = 0; j < N; j++) begin
        if (i_S == SELW'(j) && i_Valid[j]) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = SELW'(j);
          w_gnt_data = w_ch[j];
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) idx = idx - N;
        for (int j = 0; j < N; j++) begin
          if (idx == j && i_Valid[j]) begin
            w_gnt_any  = 1'b1;
            w_gnt_idx  = SELW'(j);
            w_gnt_data = w_ch[j];
          end
        end
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + SELW'(1);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_dalja <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_dalja <= w_gnt_data;
      r_sel   <= w_gnt_idx;
      r_valid <= 1'b1;
      if (i_Mode) r_ptr <= w_ptr_next;
    end else if (r_valid && i_DaljaReady) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  logic r_par;
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)     r_par <= 1'b0;
    else if (w_xfer) r_par <= ^w_gnt_data;
  end
  assign o_DaljaParitet = r_par;
`endif

  assign o_Dalja      = r_dalja;
  assign o_DaljaValid = r_valid;
  assign o_Zgjedhja   = r_sel;

endmodule

// File: tb/tb_mux_nin1_rr.sv
// Self-checking bench for mux_nin1_rr: vector table, corner sequences, random run against a model.
module tb_mux_nin1_rr;

  logic        clk, rst;
  logic [63:0] hyrja;
  logic [3:0]  valid, ready;
  logic        mode, dr, dv;
  logic [1:0]  s, zg;
  logic [15:0] dalja;
  logic        par;

  logic [47:0] h3;
  logic [2:0]  v3, rdy3;
  logic        m3, dr3, dv3;
  logic [1:0]  s3, z3;
  logic [15:0] d3;
  logic        p3;

  int errors = 0;
  int checks = 0;

  mux_nin1_rr #(.WIDTH(16), .N(4), .SELW(2)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Hyrja(hyrja), .i_Valid(valid), .o_Ready(ready),
    .i_Mode(mode), .i_S(s), .o_Dalja(dalja), .o_DaljaValid(dv), .i_DaljaReady(dr),
    .o_Zgjedhja(zg)
`ifdef MUX_PARITY_EN
    , .o_DaljaParitet(par)
`endif
  );

  mux_nin1_rr #(.WIDTH(16), .N(3), .SELW(2)) u_dut3 (
    .i_Clock(clk), .i_Reset(rst), .i_Hyrja(h3), .i_Valid(v3), .o_Ready(rdy3),
    .i_Mode(m3), .i_S(s3), .o_Dalja(d3), .o_DaljaValid(dv3), .i_DaljaReady(dr3),
    .o_Zgjedhja(z3)
`ifdef MUX_PARITY_EN
    , .o_DaljaParitet(p3)
`endif
  );

`ifndef MUX_PARITY_EN
  assign par = 1'b0;
  assign p3  = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_valid;
  logic [15:0] m_data;
  int          m_sel, m_ptr;
  bit          m_par;
  logic [3:0]  m_exp_ready;
  logic [3:0]  act_ready;

  typedef struct {
    bit          mode;
    logic [1:0]  s;
    logic [3:0]  valid;
    bit          dr;
    logic [3:0]  e_ready;
    bit          e_dv;
    logic [1:0]  e_sel;
    logic [15:0] e_data;
  } vec_t;

  vec_t tab [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ch(input int i);
    return hyrja[i*16 +: 16];
  endfunction

  // Grant by rule: explicit index if in range and valid, else first valid in ptr-rotated order.
  function automatic void model_grant(output bit any, output int g);
    int order[$];
    any = 0;
    g   = 0;
    if (!mode) begin
      if (int'(s) < 4 && valid[s]) begin
        any = 1;
        g   = int'(s);
      end
    end else begin
      for (int k = 0; k < 4; k++) order.push_back((m_ptr + k) % 4);
      foreach (order[q]) if (!any && valid[order[q]]) begin
        any = 1;
        g   = order[q];
      end
    end
  endfunction

  task automatic step();
    bit any, free;
    int g;
    logic [15:0] d;
    #1;
    act_ready = ready;
    model_grant(any, g);
    free = !m_valid || dr;
    m_exp_ready = (any && free) ? (4'b0001 << g) : 4'b0000;
    d = ch(g);
    @(posedge clk);
    if (any && free) begin
      m_valid = 1;
      m_data  = d;
      m_sel   = g;
      m_par   = ^d;
      if (mode) m_ptr = (g + 1) % 4;
    end else if (m_valid && dr) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_dalja"}, 32'(dalja), 32'h0);
    chk({tag, "_dv"},    32'(dv), 32'h0);
    chk({tag, "_zg"},    32'(zg), 32'h0);
    chk({tag, "_ready"}, 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_ready_held"}, 32'(ready), 32'h0);
    rst = 1'b0;
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_par = 0;
  endtask

  initial begin
    int fair_seq[5];
    rst = 1'b1; hyrja = '0; valid = '0; mode = 0; s = 0; dr = 0;
    h3 = '0; v3 = '0; m3 = 0; s3 = 0; dr3 = 0;
    valid = 4'b1111;
    do_reset("por");
    valid = 4'b0000;

    // Table-driven vectors from reset (ptr=0)
    tab[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
    tab[1]  = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
    tab[2]  = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
    tab[3]  = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
    tab[4]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA001};
    tab[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
    tab[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};
    tab[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
    tab[8]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'hA000};
    tab[9]  = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'hA000};
    tab[10] = '{1'b0, 2'd3, 4'b0111, 1'b0, 4'b0000, 1'b0, 2'd0, 16'hA000};
    tab[11] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 16'hA003};
    hyrja = {16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
    for (int i = 0; i < 12; i++) begin
      mode = tab[i].mode; s = tab[i].s; valid = tab[i].valid; dr = tab[i].dr;
      step();
      chk($sformatf("vec%0d_ready", i), 32'(act_ready), 32'(tab[i].e_ready));
      chk($sformatf("vec%0d_dv", i),    32'(dv),        32'(tab[i].e_dv));
      chk($sformatf("vec%0d_zg", i),    32'(zg),        32'(tab[i].e_sel));
      chk($sformatf("vec%0d_dalja", i), 32'(dalja),     32'(tab[i].e_data));
      $display("vec %0d: mode=%0d s=%0d valid=%b dr=%0d ready=%b dv=%0d zg=%0d dalja=%h",
               i, mode, s, valid, dr, act_ready, dv, zg, dalja);
    end

    // Reset during a stall drops the held word immediately
    valid = 4'b1111; dr = 0;
    chk("stall_pre_dv", 32'(dv), 32'h1);
    do_reset("midstall");

    // Round-robin fairness with pointer wrap
    fair_seq = '{0, 1, 2, 3, 0};
    hyrja = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    mode = 1; valid = 4'b1111; dr = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("fair%0d_zg", i),    32'(zg), 32'(fair_seq[i]));
      chk($sformatf("fair%0d_dalja", i), 32'(dalja), 32'(fair_seq[i]));
      chk($sformatf("fair%0d_dv", i),    32'(dv), 32'h1);
      $display("fair %0d: zg=%0d dalja=%h dv=%0d", i, zg, dalja, dv);
    end

    // Out-of-range select on the 3-channel instance
    valid = 4'b0000;
    h3 = {16'h3333, 16'h2222, 16'h1234}; m3 = 0; s3 = 0; v3 = 3'b111; dr3 = 1;
    @(posedge clk); #1;
    chk("n3_load_dv", 32'(dv3), 32'h1);
    chk("n3_load_d",  32'(d3), 32'h1234);
    s3 = 3;
    #1;
    chk("n3_oor_ready", 32'(rdy3), 32'h0);
    @(posedge clk); #1;
    chk("n3_drain_dv", 32'(dv3), 32'h0);
    chk("n3_drain_d",  32'(d3), 32'h1234);
    $display("n3: ready=%b dv=%0d d=%h", rdy3, dv3, d3);
    v3 = 0; dr3 = 0;

`ifdef MUX_PARITY_EN
    mode = 0; s = 0; valid = 4'b0001; dr = 1;
    hyrja[15:0] = 16'h0007;
    step();
    chk("par_0007", 32'(par), 32'h1);
    hyrja[15:0] = 16'h0003;
    step();
    chk("par_0003", 32'(par), 32'h0);
    $display("parity: last par=%0d", par);
`endif

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      mode  = 1'($urandom_range(0, 1));
      s     = 2'($urandom_range(0, 3));
      valid = 4'($urandom);
      dr    = ($urandom_range(0, 3) != 0);
      hyrja = {$urandom, $urandom};
      step();
      chk("rnd_ready", 32'(act_ready), 32'(m_exp_ready));
      chk("rnd_dv",    32'(dv), 32'(m_valid));
      chk("rnd_zg",    32'(zg), 32'(m_sel));
      chk("rnd_dalja", 32'(dalja), 32'(m_data));
`ifdef MUX_PARITY_EN
      chk("rnd_par",   32'(par), 32'(m_par));
`endif
      $display("rnd %0d: mode=%0d s=%0d valid=%b dr=%0d ready=%b dv=%0d zg=%0d dalja=%h",
               i, mode, s, valid, dr, act_ready, dv, zg, dalja);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
